// File: rtl/rock_ramp_ctrl.sv
// rock_ramp_ctrl: cradle rocking amplitude/frequency ramp controller (ports: clk, reset active-low async, tick, enable, stress_valid, stress_low -> amp, freq, busy, error)
module rock_ramp_ctrl #(
  parameter int RAMP_TICKS  = 4,
  parameter int CALM_TICKS  = 16,
  parameter int FAULT_TICKS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       stress_valid,
  input  logic       stress_low,
  output logic [2:0] amp,
  output logic [2:0] freq,
  output logic       busy,
  output logic       error
);
  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN, FAULT} state_t;
  localparam int CW = $clog2(RAMP_TICKS + CALM_TICKS + FAULT_TICKS + 1);
  state_t state;
  logic [CW-1:0] pace, calm_cnt, stress_cnt;
  logic stressed, calm, pace_done, full, down_freq;
  logic [2:0] up_amp, up_freq, dn_amp, dn_freq;
  always_comb begin
    stressed  = tick & stress_valid & ~stress_low;
    calm      = tick & stress_valid & stress_low;
    pace_done = pace == CW'(RAMP_TICKS - 1);
    full      = amp == 3'd7 && freq == 3'd7;
    up_amp    = (amp <= freq && amp != 3'd7) ? amp + 3'd1 : amp;
    up_freq   = (amp > freq) ? freq + 3'd1 : freq;
    down_freq = freq >= amp && freq != 3'd0;
    dn_freq   = down_freq ? freq - 3'd1 : freq;
    dn_amp    = (down_freq || amp == 3'd0) ? amp : amp - 3'd1;
  end
  assign busy  = state != IDLE;
  assign error = state == FAULT;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      amp <= '0;
      freq <= '0;
      {pace, calm_cnt, stress_cnt} <= '0;
    end else begin
      case (state)
        IDLE: if (stressed && enable) begin
          state <= RAMP_UP;
          {pace, calm_cnt, stress_cnt} <= '0;
        end
        RAMP_UP: if (tick) begin
          if (calm && enable) begin
            state <= HOLD;
            {pace, calm_cnt, stress_cnt} <= '0;
          end else begin
            pace <= pace_done ? '0 : pace + CW'(1);
            if (pace_done) {amp, freq} <= {up_amp, up_freq};
            if (!enable || (pace_done && up_amp == 3'd7 && up_freq == 3'd7)) begin
              state <= enable ? HOLD : RAMP_DOWN;
              {pace, calm_cnt, stress_cnt} <= '0;
            end
          end
        end
        HOLD: if (tick) begin
          if (!enable) begin
            state <= RAMP_DOWN;
            {pace, calm_cnt, stress_cnt} <= '0;
          end else if (calm) begin
            calm_cnt <= calm_cnt + CW'(1);
            stress_cnt <= '0;
            if (calm_cnt + CW'(1) == CW'(CALM_TICKS)) begin
              state <= RAMP_DOWN;
              {pace, calm_cnt, stress_cnt} <= '0;
            end
          end else if (stressed) begin
            stress_cnt <= stress_cnt + CW'(1);
            calm_cnt <= '0;
            if (full && stress_cnt + CW'(1) == CW'(FAULT_TICKS)) begin
              state <= FAULT;
              amp <= '0;
              freq <= '0;
              {pace, calm_cnt, stress_cnt} <= '0;
            end else if (!full && stress_cnt + CW'(1) == CW'(RAMP_TICKS)) begin
              state <= RAMP_UP;
              {pace, calm_cnt, stress_cnt} <= '0;
            end
          end
        end
        RAMP_DOWN: if (tick) begin
          pace <= pace_done ? '0 : pace + CW'(1);
          if (pace_done) {amp, freq} <= {dn_amp, dn_freq};
          if ((stressed && enable) || (pace_done && dn_amp == 3'd0 && dn_freq == 3'd0)) begin
            state <= (stressed && enable) ? RAMP_UP : IDLE;
            {pace, calm_cnt, stress_cnt} <= '0;
          end
        end
        FAULT: if (!enable) begin
          state <= IDLE;
          {pace, calm_cnt, stress_cnt} <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rock_ramp_ctrl.sv
// tb_rock_ramp_ctrl: randomized and directed checks of rock_ramp_ctrl against a level-index reference model
module tb_rock_ramp_ctrl;
  localparam int R = 4, C = 16, F = 32;
  logic clk = 0, reset = 0, tick = 0, enable = 0, stress_valid = 0, stress_low = 0;
  logic [2:0] amp, freq;
  logic busy, error;
  int n_chk = 0, n_fail = 0;
  int m_st, m_k, m_pc, m_cc, m_sc;
  rock_ramp_ctrl dut (.clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .stress_valid(stress_valid), .stress_low(stress_low), .amp(amp), .freq(freq),
    .busy(busy), .error(error));
  always #5 clk = ~clk;
  function automatic logic [7:0] exp_out();
    return {3'((m_k + 1) / 2), 3'(m_k / 2), m_st != 0, m_st == 4};
  endfunction
  function automatic logic [7:0] dut_out();
    return {amp, freq, busy, error};
  endfunction
  task automatic model_reset();
    m_st = 0; m_k = 0; m_pc = 0; m_cc = 0; m_sc = 0;
  endtask
  task automatic model_step();
    int ns = m_st;
    bit s = tick && stress_valid && !stress_low;
    bit c = tick && stress_valid && stress_low;
    bit stp = 0;
    case (m_st)
      0: if (s && enable) ns = 1;
      1: if (tick) begin
        if (c && enable) ns = 2;
        else begin
          m_pc++;
          if (m_pc == R) begin stp = 1; m_pc = 0; if (m_k < 14) m_k++; end
          if (!enable) ns = 3;
          else if (stp && m_k == 14) ns = 2;
        end
      end
      2: if (tick) begin
        if (!enable) ns = 3;
        else if (c) begin m_cc++; m_sc = 0; if (m_cc == C) ns = 3; end
        else if (s) begin
          m_sc++; m_cc = 0;
          if (m_k == 14 && m_sc == F) begin ns = 4; m_k = 0; end
          else if (m_k != 14 && m_sc == R) ns = 1;
        end
      end
      3: if (tick) begin
        m_pc++;
        if (m_pc == R) begin stp = 1; m_pc = 0; if (m_k > 0) m_k--; end
        if (s && enable) ns = 1;
        else if (stp && m_k == 0) ns = 0;
      end
      default: if (!enable) ns = 0;
    endcase
    if (ns != m_st) begin m_pc = 0; m_cc = 0; m_sc = 0; m_st = ns; end
  endtask
  task automatic cyc(input logic t, input logic e, input logic v, input logic l);
    tick = t; enable = e; stress_valid = v; stress_low = l;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick = 1'($urandom); enable = 1; stress_valid = 1; stress_low = 0;
      @(posedge clk); #1;
      n_chk++;
      if (dut_out() !== 8'h00) begin n_fail++; $display("FAIL reset_hold got=%h exp=00", dut_out()); end
    end
    reset = 1;
    cyc(0, 1, 1, 0);
    n_chk++;
    if (dut_out() !== exp_out() || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", dut_out(), exp_out()); end
  endtask
  task automatic test_ramp_fault();
    for (int i = 0; i < 57; i++) begin
      cyc(1, 1, 1, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL ramp_up[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq, busy, error} !== {3'd7, 3'd7, 2'b10}) begin n_fail++; $display("FAIL ramp_full got=%h exp=fe", dut_out()); end
    for (int i = 0; i < F; i++) begin
      cyc(1, 1, 1, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL hold_stress[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq, busy, error} !== 8'h03) begin n_fail++; $display("FAIL fault_entry got=%h exp=03", dut_out()); end
    cyc(0, 0, 0, 0);
    n_chk++;
    if ({amp, freq, busy, error} !== 8'h00) begin n_fail++; $display("FAIL fault_exit got=%h exp=00", dut_out()); end
  endtask
  task automatic test_calm_down();
    for (int i = 0; i < 41; i++) begin
      if (i % 2) cyc(0, 1, 1, 0); else cyc(1, 1, 1, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL calm_ramp[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq} !== {3'd3, 3'd2}) begin n_fail++; $display("FAIL at_3_2 got=%h exp=3/2", {amp, freq}); end
    for (int i = 0; i < 17 + 2 * R; i++) begin
      if (i < 17) cyc(1, 1, 1, 1); else cyc(1, 1, 0, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL calm_down[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq, busy} !== {3'd2, 3'd1, 1'b1}) begin n_fail++; $display("FAIL at_2_1 got=%h exp=2/1", {amp, freq}); end
    for (int i = 0; i < 1 + R; i++) begin
      if (i == 0) cyc(1, 1, 1, 0); else cyc(1, 1, 0, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL reramp[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq} !== {3'd2, 3'd2}) begin n_fail++; $display("FAIL reramp_step got=%h exp=2/2", {amp, freq}); end
    for (int i = 0; i < 17 + 4 * R; i++) begin
      if (i < 17) cyc(1, 1, 1, 1); else cyc(1, 1, 0, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL down_idle[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq, busy, error} !== 8'h00) begin n_fail++; $display("FAIL down_to_idle got=%h exp=00", dut_out()); end
  endtask
  task automatic test_enable_drop();
    for (int i = 0; i < 1 + 8 * R + 1; i++) begin
      if (i == 8 * R + 1) cyc(1, 1, 1, 1); else cyc(1, 1, 1, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL to_4_4[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq, busy} !== {3'd4, 3'd4, 1'b1}) begin n_fail++; $display("FAIL hold_4_4 got=%h exp=4/4", {amp, freq}); end
    for (int i = 0; i < 1 + 8 * R + 4; i++) begin
      cyc(1, 0, 1, 0);
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL en_drop[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
    n_chk++;
    if ({amp, freq, busy, error} !== 8'h00) begin n_fail++; $display("FAIL en_drop_idle got=%h exp=00", dut_out()); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 1 + 3 * R; i++) cyc(1, 1, 1, 0);
    n_chk++;
    if (dut_out() !== exp_out() || busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset got=%h exp=%h", dut_out(), exp_out()); end
    #2 reset = 0;
    #1;
    n_chk++;
    if ({amp, freq, busy, error} !== 8'h00) begin n_fail++; $display("FAIL async_reset got=%h exp=00", dut_out()); end
    model_reset();
    @(negedge clk) reset = 1;
    cyc(0, 1, 1, 0);
    n_chk++;
    if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL post_reset got=%h exp=%h", dut_out(), exp_out()); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) != 0),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) < (i % 800 < 400 ? 3 : 7)));
      n_chk++;
      if (dut_out() !== exp_out()) begin n_fail++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_out(), exp_out()); end
    end
  endtask
  initial begin
    test_reset();
    test_ramp_fault();
    test_calm_down();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
